// File: rtl/por_reset_sequencer_if.sv
// Per-domain reset/acknowledge handshake and status bundle for the POR reset sequencer.
// The sequencer uses the master view; the core reset tree side uses the slave view.
interface por_reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
);
    logic [NUM_DOMAINS-1:0] domain_ack_i;
    logic [NUM_DOMAINS-1:0] domain_rst_o;
    logic                   seq_done_o;
    logic                   timeout_o;
    logic [IDX_W-1:0]       fault_idx_o;
    logic [2:0]             state_o;

    modport master (
        input  domain_ack_i,
        output domain_rst_o,
        output seq_done_o,
        output timeout_o,
        output fault_idx_o,
        output state_o
    );

    modport slave (
        output domain_ack_i,
        input  domain_rst_o,
        input  seq_done_o,
        input  timeout_o,
        input  fault_idx_o,
        input  state_o
    );
endinterface

// File: rtl/por_reset_sequencer.sv
// Synchronises and stretches the POR cell output, then releases the core reset domains
// one at a time, waiting for each domain's acknowledge before moving on.
module por_reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int STRETCH_CYCLES = 256,
    parameter int STAGE_GAP      = 16,
    parameter int ACK_TIMEOUT    = 1024,
    parameter int CNT_W          = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        por_n_i,
    por_reset_sequencer_if.master       bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_STRETCH  = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    // Two-flop synchroniser; por_n_i feeds the first flop directly.
    logic r_sync1;
    logic r_sync2;
    logic w_por_s;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_next;
    logic [NUM_DOMAINS-1:0]  r_dom_rst;
    logic [NUM_DOMAINS-1:0]  w_dom_rst_next;
    logic                    r_seq_done;
    logic                    w_seq_done_next;
    logic                    r_timeout;
    logic                    w_timeout_next;
    logic [IDX_W-1:0]        r_fault_idx;
    logic [IDX_W-1:0]        w_fault_idx_next;

    logic w_ack;
    logic w_rst_all;
    logic w_release;

    assign w_por_s = r_sync2;
    assign w_ack   = bus.domain_ack_i[r_idx];

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idx_next       = r_idx;
        w_seq_done_next  = r_seq_done;
        w_timeout_next   = r_timeout;
        w_fault_idx_next = r_fault_idx;
        w_rst_all        = 1'b0;
        w_release        = 1'b0;

        // Brownout overrides every in-flight decision; fault status is deliberately kept.
        if ((r_state != ST_HOLD) && !w_por_s) begin
            w_state_next    = ST_HOLD;
            w_cnt_next      = '0;
            w_rst_all       = 1'b1;
            w_seq_done_next = 1'b0;
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    w_rst_all = 1'b1;
                    if (w_por_s) begin
                        w_state_next = ST_STRETCH;
                        w_cnt_next   = '0;
                    end
                end
                ST_STRETCH: begin
                    if (r_cnt == STRETCH_LAST) begin
                        w_state_next = ST_RELEASE;
                        w_idx_next   = '0;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    w_release    = 1'b1;
                    w_state_next = ST_WAIT_ACK;
                    w_cnt_next   = '0;
                end
                ST_WAIT_ACK: begin
                    // Acknowledge is checked first so it wins over a coincident timeout.
                    if (w_ack) begin
                        w_cnt_next = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_next    = ST_DONE;
                            w_seq_done_next = 1'b1;
                        end else begin
                            w_state_next = ST_GAP;
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_state_next     = ST_FAULT;
                        w_timeout_next   = 1'b1;
                        w_fault_idx_next = r_idx;
                        w_rst_all        = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_next = ST_RELEASE;
                        w_idx_next   = r_idx + 1'b1;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                ST_FAULT: begin
                    w_rst_all = 1'b1;
                end
                default: begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = '0;
                    w_rst_all    = 1'b1;
                end
            endcase
        end
    end

    // Each domain bit is either forced high, cleared on its own release, or held.
    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
            assign w_dom_rst_next[gi] = w_rst_all ? 1'b1 :
                                        ((w_release && (r_idx == IDX_W'(gi))) ? 1'b0 :
                                                                                r_dom_rst[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom_rst   <= '1;
            r_seq_done  <= 1'b0;
            r_timeout   <= 1'b0;
            r_fault_idx <= '0;
        end else begin
            r_sync1     <= por_n_i;
            r_sync2     <= r_sync1;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_dom_rst   <= w_dom_rst_next;
            r_seq_done  <= w_seq_done_next;
            r_timeout   <= w_timeout_next;
            r_fault_idx <= w_fault_idx_next;
        end
    end

    assign bus.domain_rst_o = r_dom_rst;
    assign bus.seq_done_o   = r_seq_done;
    assign bus.timeout_o    = r_timeout;
    assign bus.fault_idx_o  = r_fault_idx;
    assign bus.state_o      = r_state;

endmodule
